mod_10_counter: RTL and testbench

MOD_10_COUNTER -- requirements
Module: mod_10_counter

---
 rtl/mod_10_counter.sv | 94 +++++++++
 tb/tb_mod_10_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_10_counter.sv
// Modulo-N up-counter with terminal-count flag, wrap carry pulse and a
// seven-segment decode of the current count. The default build is a decade
// counter (0..9).
//
// Note: rst_n is asserted high and acts asynchronously. The name is kept
// for compatibility with existing instantiations.
module mod_10_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry,
  output logic [6:0]       seg
);

  // Last legal count value, and the increment step, both at count width.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Seven-segment patterns, bit order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic             at_last;
  logic             out_of_range;
  logic [WIDTH-1:0] q_next;
  logic [31:0]      q_wide;

  assign at_last      = (q == LAST);
  assign out_of_range = (q > LAST);
  assign q_wide       = 32'(q);

  // Terminal count is decoded directly from the registered count.
  assign tc = at_last;

  // Next count. Both the wrap and the recovery from an illegal value load
  // zero explicitly, so nothing relies on natural 2**WIDTH rollover.
  always_comb begin
    q_next = q + ONE;
    if (at_last || out_of_range) begin
      q_next = '0;
    end
  end

  // Count register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Carry is high for the single cycle after a MODULUS-1 -> 0 wrap. An
  // illegal-value recovery to zero is not a wrap and does not pulse it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      carry <= 1'b0;
    end else begin
      carry <= at_last;
    end
  end

  // Decimal digit to seven-segment decode; anything above 9 blanks the digit.
  always_comb begin
    seg = SEG_BLANK;
    case (q_wide)
      32'd0:   seg = SEG_0;
      32'd1:   seg = SEG_1;
      32'd2:   seg = SEG_2;
      32'd3:   seg = SEG_3;
      32'd4:   seg = SEG_4;
      32'd5:   seg = SEG_5;
      32'd6:   seg = SEG_6;
      32'd7:   seg = SEG_7;
      32'd8:   seg = SEG_8;
      32'd9:   seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_mod_10_counter.sv
// Scoreboard bench for mod_10_counter: a default decade instance and a
// MODULUS=6 / WIDTH=3 instance share clock and reset. Stimulus advances an
// arithmetic reference model and queues the expected outputs. A monitor
// pops and compares after every clock edge and after every reset assertion.
module tb_mod_10_counter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] q10;
  logic       tc10;
  logic       carry10;
  logic [6:0] seg10;

  logic [2:0] q6;
  logic       tc6;
  logic       carry6;
  logic [6:0] seg6;

  always #5 clk = ~clk;

  mod_10_counter dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q10),
    .tc    (tc10),
    .carry (carry10),
    .seg   (seg10)
  );

  mod_10_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q6),
    .tc    (tc6),
    .carry (carry6),
    .seg   (seg6)
  );

  typedef struct {
    int q10;
    int tc10;
    int carry10;
    int seg10;
    int q6;
    int tc6;
    int carry6;
    int seg6;
  } exp_t;

  exp_t sb[$];

  // Digit patterns {g,f,e,d,c,b,a} for 0..9.
  int seg_table [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  int m10_q = 0;
  int m10_c = 0;
  int m6_q  = 0;
  int m6_c  = 0;

  int errors = 0;
  int checks = 0;

  function automatic exp_t snapshot();
    exp_t e;
    e.q10     = m10_q;
    e.tc10    = (m10_q == 9) ? 1 : 0;
    e.carry10 = m10_c;
    e.seg10   = seg_table[m10_q];
    e.q6      = m6_q;
    e.tc6     = (m6_q == 5) ? 1 : 0;
    e.carry6  = m6_c;
    e.seg6    = seg_table[m6_q];
    return e;
  endfunction

  task automatic model_reset();
    m10_q = 0;
    m10_c = 0;
    m6_q  = 0;
    m6_c  = 0;
  endtask

  // One rising clock edge as seen by the reference model.
  task automatic model_edge();
    if (rst_n) begin
      model_reset();
    end else begin
      m10_c = (m10_q == 9) ? 1 : 0;
      m10_q = (m10_q + 1) % 10;
      m6_c  = (m6_q == 5) ? 1 : 0;
      m6_q  = (m6_q + 1) % 6;
    end
  endtask

  task automatic push_expect();
    sb.push_back(snapshot());
  endtask

  // One clock cycle with reset level r. A fresh reset assertion is itself an
  // observable event, so its expectation is queued before rst_n rises.
  task automatic clock_cycle(input logic r);
    if (r && !rst_n) begin
      model_reset();
      push_expect();
      rst_n = 1'b1;
    end else begin
      rst_n = r;
    end
    model_edge();
    push_expect();
    @(negedge clk);
  endtask

  // Count one edge, then assert reset 3 ns after that edge. Hold it across
  // the next edge and release it 3 ns after that edge.
  task automatic async_pulse();
    rst_n = 1'b0;
    model_edge();
    push_expect();
    @(posedge clk);
    #3;
    model_reset();
    push_expect();
    rst_n = 1'b1;
    @(negedge clk);
    model_edge();
    push_expect();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp_v);
    checks++;
    if (act !== 32'(exp_v)) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compare after every clock edge and every reset assertion.
  initial begin
    exp_t e;
    #1;
    forever begin
      @(posedge clk or posedge rst_n);
      #2;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("q10",     32'(q10),     e.q10);
        check("tc10",    32'(tc10),    e.tc10);
        check("carry10", 32'(carry10), e.carry10);
        check("seg10",   32'(seg10),   e.seg10);
        check("q6",      32'(q6),      e.q6);
        check("tc6",     32'(tc6),     e.tc6);
        check("carry6",  32'(carry6),  e.carry6);
        check("seg6",    32'(seg6),    e.seg6);
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    // Held reset over two edges.
    clock_cycle(1'b1);
    clock_cycle(1'b1);
    // Release, then run twelve edges through the first wrap.
    for (int i = 0; i < 12; i++) clock_cycle(1'b0);
    // Free run of twenty edges starting from zero.
    while (m10_q != 0) clock_cycle(1'b0);
    for (int i = 0; i < 20; i++) clock_cycle(1'b0);
    // Asynchronous reset while the decade count sits at 5.
    while (m10_q != 4) clock_cycle(1'b0);
    async_pulse();
    for (int i = 0; i < 4; i++) clock_cycle(1'b0);
    // Randomized run with sporadic synchronous-edge and mid-cycle resets.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) async_pulse();
      else if (r == 1) clock_cycle(1'b1);
      else clock_cycle(1'b0);
    end
    for (int i = 0; i < 3; i++) clock_cycle(1'b0);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
